// File: rtl/gf_mixcol_engine.sv
// gf_mixcol_engine: (Inv)MixColumns over an NCOL-column state, LANES columns per cycle; GF_MIXCOL_FWD_EN builds forward mode.
// Latency: out_valid rises NCOL/LANES cycles after the accept edge.
// Backpressure: in_ready only in IDLE; dout/out_valid held in DONE until out_ready.
module gf_mixcol_engine #(
  parameter int NCOL  = 4,
  parameter int LANES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [32*NCOL-1:0] din,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NCOL-1:0] dout,
  output logic              busy
);
  localparam int STEPS = NCOL / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int W     = 32 * NCOL;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] x9;
    logic [7:0] xb;
    logic [7:0] xd;
    logic [7:0] xe;
  } inv_mul_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   work_q, work_nx, dout_q;
  logic           out_valid_q;
  logic           last_step;
  logic           accept;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic inv_mul_t inv_mul(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    inv_mul_t   m;
    x2   = xtime(a);
    x4   = xtime(x2);
    x8   = xtime(x4);
    m.x9 = x8 ^ a;
    m.xb = x8 ^ x2 ^ a;
    m.xd = x8 ^ x4 ^ a;
    m.xe = x8 ^ x4 ^ x2;
    return m;
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    inv_mul_t m0, m1, m2, m3;
    m0 = inv_mul(c[31:24]);
    m1 = inv_mul(c[23:16]);
    m2 = inv_mul(c[15:8]);
    m3 = inv_mul(c[7:0]);
    return {m0.xe ^ m1.xb ^ m2.xd ^ m3.x9,
            m0.x9 ^ m1.xe ^ m2.xb ^ m3.xd,
            m0.xd ^ m1.x9 ^ m2.xe ^ m3.xb,
            m0.xb ^ m1.xd ^ m2.x9 ^ m3.xe};
  endfunction

`ifdef GF_MIXCOL_FWD_EN
  logic mode_q;

  // 3*a is folded as xtime(a)^a; no separate multiplier needed.
  function automatic logic [31:0] fwd_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, d0, d1, d2, d3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    d0 = xtime(a0);
    d1 = xtime(a1);
    d2 = xtime(a2);
    d3 = xtime(a3);
    return {d0 ^ d1 ^ a1 ^ a2 ^ a3,
            a0 ^ d1 ^ d2 ^ a2 ^ a3,
            a0 ^ a1 ^ d2 ^ d3 ^ a3,
            d0 ^ a0 ^ a1 ^ a2 ^ d3};
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      mode_q <= 1'b0;
    else if (accept)
      mode_q <= mode;
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt_q == CW'(STEPS - 1));

  // Column idx lives at bit offset 32*(NCOL-1-idx) = W-32*(idx+1).
  always_comb begin
    int base;
    work_nx = work_q;
    base    = int'(cnt_q) * LANES;
    for (int l = 0; l < LANES; l++) begin
`ifdef GF_MIXCOL_FWD_EN
      work_nx[W-32*(base+l+1) +: 32] = mode_q ? fwd_col(work_q[W-32*(base+l+1) +: 32])
                                              : inv_col(work_q[W-32*(base+l+1) +: 32]);
`else
      work_nx[W-32*(base+l+1) +: 32] = inv_col(work_q[W-32*(base+l+1) +: 32]);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = !rst;
        if (accept)
          state_d = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_step)
          state_d = S_DONE;
      end
      S_DONE: begin
        busy = 1'b1;
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      work_q      <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            work_q <= din;
            cnt_q  <= '0;
          end
        end
        S_RUN: begin
          work_q <= work_nx;
          cnt_q  <= cnt_q + CW'(1);
          if (last_step) begin
            dout_q      <= work_nx;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready)
            out_valid_q <= 1'b0;
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_gf_mixcol_engine.sv
// Bench for gf_mixcol_engine: directed spec vectors plus random blocks against a polynomial-multiply reference model.
module tb_gf_mixcol_engine;
  logic         clk;
  logic         rst;
  logic         in_valid, in_valid_l;
  logic         mode;
  logic [127:0] din;
  logic         out_ready, out_ready_l;
  logic         in_ready, out_valid, busy;
  logic [127:0] dout;
  logic         in_ready2, out_valid2, busy2;
  logic [127:0] dout2;
  logic         in_ready4, out_valid4, busy4;
  logic [127:0] dout4;

  int errors = 0;
  int checks = 0;

`ifdef GF_MIXCOL_FWD_EN
  localparam logic FWD_BUILT = 1'b1;
`else
  localparam logic FWD_BUILT = 1'b0;
`endif

  localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_d4bf5d30_c6c6c6c6;
  localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_046681e5_c6c6c6c6;
  localparam logic [127:0] UNIT_IN  = 128'h01000000_00000000_00000100_00000000;
  localparam logic [127:0] UNIT_OUT = 128'h0e090d0b_00000000_0d0b0e09_00000000;

  gf_mixcol_engine #(.NCOL(4), .LANES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .busy(busy));

  gf_mixcol_engine #(.NCOL(4), .LANES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready2), .mode(mode), .din(din),
    .out_valid(out_valid2), .out_ready(out_ready_l), .dout(dout2), .busy(busy2));

  gf_mixcol_engine #(.NCOL(4), .LANES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_l), .in_ready(in_ready4), .mode(mode), .din(din),
    .out_valid(out_valid4), .out_ready(out_ready_l), .dout(dout4), .busy(busy4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog");
  end

  // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s, input logic fwd);
    logic [7:0]   coef [4];
    logic [31:0]  col;
    logic [7:0]   acc;
    logic [127:0] r;
    if (fwd) begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end else begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      col = s[127-32*c -: 32];
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - row + 4) % 4], col[31-8*k -: 8]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one block, then counts cycles from the accept edge to out_valid.
  task automatic run_block(input logic [127:0] d, input logic m, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_wait: in_ready=%0b, required 1 within 20 cycles", in_ready);
    end
    checks++;
    in_valid = 1'b1;
    din      = d;
    mode     = m;
    step();
    in_valid = 1'b0;
    mode     = ~m;
    din      = {$urandom(), $urandom(), $urandom(), $urandom()};
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic release_block();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_valid_l = 1'b0; out_ready = 1'b0; out_ready_l = 1'b0;
    mode = 1'b0; din = '0;
    step();
    step();
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    checks++;
    if (dout !== 128'h0) begin errors++; $display("FAIL rst_dout: got %h required 0", dout); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b required 0", busy); end
    checks++;
    rst = 1'b0;
    step();
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %0b required 1", in_ready); end
    checks++;
  endtask

  task automatic test_inverse();
    int lat;
    run_block(INV_IN, 1'b0, lat);
    if (lat !== 4) begin errors++; $display("FAIL inv_latency: got %0d required 4", lat); end
    checks++;
    if (dout !== INV_OUT) begin errors++; $display("FAIL inv_dout: got %h required %h", dout, INV_OUT); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL inv_busy_done: got %0b required 1", busy); end
    checks++;
    release_block();
    if (out_valid !== 1'b0) begin errors++; $display("FAIL inv_release_valid: got %0b required 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL inv_back_idle: in_ready=%0b busy=%0b required 1/0", in_ready, busy);
    end
    checks++;
  endtask

  task automatic test_forward();
    int lat;
    logic [127:0] exp;
    exp = FWD_BUILT ? FWD_OUT : ref_state(FWD_IN, 1'b0);
    run_block(FWD_IN, 1'b1, lat);
    if (dout !== exp) begin errors++; $display("FAIL fwd_dout: got %h required %h", dout, exp); end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL fwd_latency: got %0d required 4", lat); end
    checks++;
    release_block();
  endtask

  task automatic test_unit_vectors();
    int lat;
    run_block(UNIT_IN, 1'b0, lat);
    if (dout !== UNIT_OUT) begin errors++; $display("FAIL unit_dout: got %h required %h", dout, UNIT_OUT); end
    checks++;
    release_block();
  endtask

  task automatic test_random();
    int lat;
    logic [127:0] d, exp;
    logic m;
    for (int i = 0; i < 16; i++) begin
      d   = {$urandom(), $urandom(), $urandom(), $urandom()};
      m   = 1'($urandom_range(0, 1));
      exp = ref_state(d, m && FWD_BUILT);
      run_block(d, m, lat);
      if (dout !== exp || lat !== 4) begin
        errors++;
        $display("FAIL rand_%0d: dout=%h lat=%0d required %h lat=4", i, dout, lat, exp);
      end
      checks++;
      repeat ($urandom_range(0, 2)) step();
      release_block();
    end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    logic [127:0] a, b, exp_a, exp_b;
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp_a = ref_state(a, 1'b0);
    exp_b = ref_state(b, 1'b0);
    run_block(a, 1'b0, lat);
    in_valid = 1'b1;
    din      = b;
    mode     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (dout !== exp_a || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: dout=%h ov=%0b ir=%0b required %h/1/0", i, dout, out_valid, in_ready, exp_a);
      end
      checks++;
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_bypass: busy=%0b ov=%0b required 0/0", busy, out_valid);
    end
    checks++;
    step();
    in_valid = 1'b0;
    if (busy !== 1'b1) begin errors++; $display("FAIL bp_accept_next: busy=%0b required 1", busy); end
    checks++;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (n !== 4 || dout !== exp_b) begin
      errors++;
      $display("FAIL bp_second_block: dout=%h lat=%0d required %h lat=4", dout, n, exp_b);
    end
    checks++;
    release_block();
  endtask

  task automatic test_reset_midrun();
    int lat, n;
    logic [127:0] d, exp;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    in_valid = 1'b1;
    din      = INV_IN;
    mode     = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    if (out_valid !== 1'b0 || dout !== 128'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrun_rst: ov=%0b dout=%h busy=%0b ir=%0b required 0/0/0/0", out_valid, dout, busy, in_ready);
    end
    checks++;
    rst = 1'b0;
    step();
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrun_ready: got %0b required 1", in_ready); end
    checks++;
    d   = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp = ref_state(d, 1'b0);
    run_block(d, 1'b0, lat);
    if (dout !== exp || lat !== 4) begin
      errors++;
      $display("FAIL midrun_fresh: dout=%h lat=%0d required %h lat=4", dout, lat, exp);
    end
    checks++;
    release_block();
  endtask

  task automatic test_lanes();
    int n, lat2, lat4;
    logic [127:0] d2, d4;
    if (in_ready2 !== 1'b1 || in_ready4 !== 1'b1) begin
      errors++;
      $display("FAIL lanes_ready: ir2=%0b ir4=%0b required 1/1", in_ready2, in_ready4);
    end
    checks++;
    in_valid_l = 1'b1;
    din        = INV_IN;
    mode       = 1'b0;
    step();
    in_valid_l = 1'b0;
    mode       = 1'b1;
    n = 0; lat2 = -1; lat4 = -1; d2 = '0; d4 = '0;
    while ((lat2 < 0 || lat4 < 0) && n < 10) begin
      step();
      n++;
      if (out_valid2 && lat2 < 0) begin lat2 = n; d2 = dout2; end
      if (out_valid4 && lat4 < 0) begin lat4 = n; d4 = dout4; end
    end
    if (lat4 !== 1 || d4 !== INV_OUT) begin
      errors++;
      $display("FAIL lanes4: dout=%h lat=%0d required %h lat=1", d4, lat4, INV_OUT);
    end
    checks++;
    if (lat2 !== 2 || d2 !== INV_OUT) begin
      errors++;
      $display("FAIL lanes2: dout=%h lat=%0d required %h lat=2", d2, lat2, INV_OUT);
    end
    checks++;
    out_ready_l = 1'b1;
    step();
    out_ready_l = 1'b0;
    if (out_valid2 !== 1'b0 || out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL lanes_release: ov2=%0b ov4=%0b required 0/0", out_valid2, out_valid4);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_inverse();
    test_forward();
    test_unit_vectors();
    test_random();
    test_back_to_back();
    test_reset_midrun();
    test_lanes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gf_mixcol_engine.md
Name: gf_mixcol_engine

Overview:
- Multi-cycle, parametrised column-mixing engine for the AES datapath; successor to the per-byte constant-multiply lookup tables.
- Computes InvMixColumns, and optionally forward MixColumns, over a full NCOL-column state.
- Processes LANES columns per cycle with arithmetic GF(2^8) xtime chains instead of ROMs.
- Sits between InvShiftRows/InvSubBytes and AddRoundKey in the round loop, with valid/ready handshakes on both sides.

Parameters:
- NCOL, 4, columns per state word (4 = AES-128 state); must be >= 1.
- LANES, 1, columns transformed per RUN cycle; must divide NCOL.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, din/mode valid.
- in_ready, output, 1, engine can accept; high only in IDLE and while rst=0.
- mode, input, 1, 0 = inverse (InvMixColumns), 1 = forward (MixColumns); sampled on acceptance.
- din, input, 32*NCOL, state. Column c = din[32*(NCOL-1-c) +: 32]; row 0 byte is the most significant byte of each column.
- out_valid, output, 1, dout valid; held until out_ready.
- out_ready, input, 1, downstream accepts dout.
- dout, output, 32*NCOL, transformed state, same packing as din.
- busy, output, 1, high in RUN or DONE.

Behaviour:
- Reset (synchronous, highest priority, any state incl. mid-RUN):
  - state=IDLE, column counter=0, out_valid=0, busy=0, dout=0, internal state register=0.
  - in_ready=0 during the rst cycle; 1 from the first cycle after rst deasserts.
  - A partial transform is discarded.
- FSM IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On an edge with in_valid && in_ready: capture din into the working register, latch mode, counter=0, go RUN.
  - Otherwise hold.
- RUN:
  - Each edge replaces columns counter*LANES .. counter*LANES+LANES-1 of the working register with their transform, then counter += 1.
  - in_valid is ignored in RUN.
  - On the edge where counter = NCOL/LANES-1: copy the fully transformed register to dout, set out_valid=1, go DONE.
  - Latency: out_valid is visible NCOL/LANES cycles after the acceptance edge (4 cycles at defaults; 1 cycle when LANES=NCOL).
- DONE:
  - dout and out_valid are held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid=0, go IDLE; in_ready returns the following cycle.
  - No bypass: consecutive blocks are spaced by NCOL/LANES+2 cycles minimum.
- GF arithmetic:
  - xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 8'h00).
  - x9 = x8^a, xB = x8^x2^a, xD = x8^x4^a, xE = x8^x4^x2, where x2=xtime(a), x4=xtime(x2), x8=xtime(x4).
  - All results are 8-bit; no carries.
- Inverse, per column a0..a3:
  - r0 = E·a0 ^ B·a1 ^ D·a2 ^ 9·a3
  - r1 = 9·a0 ^ E·a1 ^ B·a2 ^ D·a3
  - r2 = D·a0 ^ 9·a1 ^ E·a2 ^ B·a3
  - r3 = B·a0 ^ D·a1 ^ 9·a2 ^ E·a3
- Forward: coefficient rows {2,3,1,1} rotated the same way.
- Simultaneous events:
  - rst overrides any handshake.
  - in_valid asserted during DONE while out_ready=1 is not accepted in that cycle.
  - mode changes after acceptance have no effect on the block in flight.

Optional Feature:
- Macro GF_MIXCOL_FWD_EN.
- Defined: mode selects forward/inverse as above.
- Undefined:
  - Forward multiplier logic is not synthesised and mode is ignored; the engine always performs InvMixColumns.
  - The mode port still exists, so the port list is unchanged.

Test Plan:
- Inverse, defaults: din=8e4da1bc_9fdc589d_01010101_c6c6c6c6, mode=0 -> dout=db135345_f20a225c_01010101_c6c6c6c6, out_valid exactly 4 cycles after acceptance.
- Forward (macro defined): din=db135345_f20a225c_d4bf5d30_c6c6c6c6, mode=1 -> dout=8e4da1bc_9fdc589d_046681e5_c6c6c6c6. With the macro undefined, mode=1 yields the inverse result instead.
- Unit-vector coefficient check, inverse: column 01000000 -> 0e090d0b; column 00000100 -> 0d0b0e09; remaining columns 00000000 -> 00000000.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> dout stable, in_ready=0 throughout; next block accepted only after the out_ready handshake.
- Reset mid-RUN: assert rst on the 2nd RUN cycle -> next cycle out_valid=0, dout=0, busy=0; in_ready=1 the cycle after rst drops; a fresh block then completes with correct data.
- LANES=4, NCOL=4: same vectors as the inverse scenario -> out_valid 1 cycle after acceptance. LANES=2 -> 2 cycles.
